// File: rtl/data_memory.sv
// Multi-cycle data memory for the MEM stage: byte/half/word loads and stores.
// Holds the pipeline with BUSYWAIT for LATENCY cycles per access.
module data_memory #(
   parameter int unsigned LATENCY     = 3,
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [2:0]  FUNC3,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITE_DATA,
   output logic [31:0] DATA_OUT,
   output logic        BUSYWAIT
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [2:0]    func3_q, func3_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          store_q, store_d;
   logic [31:0]   data_out_q, data_out_d;

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic          mem_we;
   logic [31:0]   mem_wdata;

   logic [AW-1:0] idx;
   logic [31:0]   rd_word;
   logic [31:0]   rd_shift;
   logic [31:0]   wr_shift;
   logic [31:0]   ld_val;
   logic [31:0]   ld_res;
   logic [3:0]    be;
   logic          ld_ok;
   logic          st_ok;
   logic          req;
   logic          unused_addr;

   // Upper address bits fold away: the array wraps around.
   assign unused_addr = ^ADDRESS[31:AW+2];

   assign req      = READ | WRITE;
   assign idx      = addr_q[AW+1:2];
   assign rd_word  = mem_q[idx];
   assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};
   assign wr_shift = wdata_q << {addr_q[1:0], 3'b000};

   assign BUSYWAIT = !RESET &&
                     (((state_q == IDLE) && req) || (state_q == WAIT));
   assign DATA_OUT = data_out_q;

   always_comb begin
      ld_ok  = 1'b0;
      st_ok  = 1'b0;
      be     = 4'b0000;
      ld_val = 32'h0;
      case (func3_q)
         3'b000: begin
            ld_ok  = 1'b1;
            st_ok  = 1'b1;
            be     = 4'b0001 << addr_q[1:0];
            ld_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
         end
         3'b001: begin
            ld_ok  = !addr_q[0];
            st_ok  = !addr_q[0];
            be     = addr_q[1] ? 4'b1100 : 4'b0011;
            ld_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
         end
         3'b010: begin
            ld_ok  = (addr_q[1:0] == 2'b00);
            st_ok  = (addr_q[1:0] == 2'b00);
            be     = 4'b1111;
            ld_val = rd_word;
         end
         3'b100: begin
            ld_ok  = 1'b1;
            ld_val = {24'h0, rd_shift[7:0]};
         end
         3'b101: begin
            ld_ok  = !addr_q[0];
            ld_val = {16'h0, rd_shift[15:0]};
         end
         default: ;
      endcase
   end

   assign ld_res = (!store_q && ld_ok) ? ld_val : 32'h0;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         mem_wdata[i*8 +: 8] = be[i] ? wr_shift[i*8 +: 8]
                                     : rd_word[i*8 +: 8];
      end
   end

   // Array write happens on the WAIT->DONE edge, never under reset.
   assign mem_we = !RESET && (state_q == WAIT) && (cnt_q == 4'd0) &&
                   store_q && st_ok;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      func3_d    = func3_q;
      wdata_d    = wdata_q;
      store_d    = store_q;
      data_out_d = data_out_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = WAIT;
               cnt_d   = 4'(LATENCY - 2);
               addr_d  = ADDRESS[AW+1:0];
               func3_d = FUNC3;
               wdata_d = WRITE_DATA;
               store_d = WRITE;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d    = DONE;
               data_out_d = ld_res;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (RESET) begin
         state_d    = IDLE;
         cnt_d      = 4'd0;
         data_out_d = 32'h0;
      end
   end

   always_ff @(posedge CLK) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      func3_q    <= func3_d;
      wdata_q    <= wdata_d;
      store_q    <= store_d;
      data_out_q <= data_out_d;
   end

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem_q[idx] <= mem_wdata;
      end
   end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LATENCY, default 3, BUSYWAIT cycles per access; legal range 2..15.
REQ-002 Parameter DEPTH_WORDS, default 256, number of 32-bit storage words; power of two.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 CLK  input  1  clock; all state updates on the posedge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 READ  input  1  load request from the MEM stage.
REQ-007 WRITE  input  1  store request from the MEM stage.
REQ-008 FUNC3  input  3  RV32 funct3 of the load or store.
REQ-009 ADDRESS  input  32  byte address (ALU result).
REQ-010 WRITE_DATA  input  32  store data, rs2 value, right-aligned.
REQ-011 DATA_OUT  output  32  registered load result, feeding the MEM/WB register's IN_DMEM_OUT.
REQ-012 BUSYWAIT  output  1  stall request to the PC and all pipeline registers.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and DONE, plus a 4-bit down-counter CNT.
REQ-014 BUSYWAIT SHALL be combinational: 1 when !RESET and ((IDLE and (READ or WRITE)) or WAIT), otherwise 0.
REQ-015 IDLE with READ or WRITE at posedge -> WAIT; CNT=LATENCY-2; ADDRESS, FUNC3, WRITE_DATA and op type latched.
REQ-016 WAIT, CNT!=0 at posedge -> CNT decrements.
REQ-017 WAIT, CNT==0 at posedge -> DONE; array access performed on this edge; load result registered into DATA_OUT.
REQ-018 DONE -> IDLE unconditionally at the next posedge; BUSYWAIT=0 throughout DONE, so the pipeline advances on that edge.
REQ-019 Net timing: BUSYWAIT high for exactly LATENCY consecutive cycles, starting in the request cycle; DATA_OUT is valid in the following cycle.
REQ-020 Inputs are sampled only at acceptance; input changes or deassertion during WAIT SHALL NOT affect the access in flight.
REQ-021 Word index SHALL be ADDRESS[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored (wrap-around).
REQ-022 Loads by FUNC3:
- 000 LB: byte at lane ADDRESS[1:0], sign-extended.
- 001 LH: half at lane ADDRESS[1], sign-extended.
- 010 LW: full word.
- 100 LBU: byte, zero-extended.
- 101 LHU: half, zero-extended.
REQ-023 Stores by FUNC3, with all other lanes unchanged:
- 000 SB: WRITE_DATA[7:0] into the lane selected by ADDRESS[1:0].
- 001 SH: WRITE_DATA[15:0] into the half selected by ADDRESS[1].
- 010 SW: full word.
REQ-024 Misaligned access (half with ADDRESS[0]=1, or word with ADDRESS[1:0]!=0) or undefined FUNC3 SHALL complete with normal latency, perform no array write and give DATA_OUT=0.
REQ-025 READ and WRITE both high SHALL be treated as a store; DATA_OUT=0 for that access.
REQ-026 After a store completes, DATA_OUT=0; DATA_OUT SHALL otherwise hold its value until the next DONE entry.
REQ-027 Back-to-back requests: a request present in IDLE immediately after DONE starts a new access; there SHALL be no idle bubble beyond the DONE cycle.

Reset
REQ-028 With RESET high at posedge: state=IDLE, CNT=0, DATA_OUT=0; BUSYWAIT=0 combinationally while RESET is high.
REQ-029 Reset during WAIT SHALL abort the access with no array write; reset on the WAIT->DONE edge SHALL also suppress the write.
REQ-030 Array contents SHALL NOT be cleared by reset.

Verification
REQ-031 SW then LW: WRITE=1, FUNC3=010, ADDRESS=0x10, WRITE_DATA=0xDEADBEEF; then READ=1 at 0x10 -> BUSYWAIT high 3 cycles per access, DATA_OUT=0xDEADBEEF in the 4th cycle of the load.
REQ-032 SB then loads: SB 0x80 at 0x11 onto word 0x00000000 -> LW 0x10 gives 0x00008000; LB 0x11 gives 0xFFFFFF80; LBU 0x11 gives 0x00000080.
REQ-033 SH then loads: SH 0x1234 at 0x22 onto zero word 0x20 -> LW 0x20 gives 0x12340000; LH 0x22 gives 0x00001234.
REQ-034 Misaligned and wrap: LW at 0x13 -> DATA_OUT=0, no write; SW at 0x400 with DEPTH_WORDS=256 -> LW 0x0 returns that data.
REQ-035 Reset mid-operation: SW 0xCAFEF00D at 0x30, RESET high in the 2nd BUSYWAIT cycle -> BUSYWAIT=0 and IDLE; a later LW 0x30 returns the prior contents.
REQ-036 Back-to-back with inputs changed during WAIT: READ 0x10 then WRITE 0x14, inputs altered mid-WAIT -> each access uses its accepted values; BUSYWAIT low only in each DONE cycle.
